// File: rtl/x_lut_cfg_loader.sv
// Serialises W-bit configuration words MSB-first onto a LUT setup chain, CHAIN_BITS bits per load.
// Optional parity accumulator on o_parity is enabled by defining X_LUT_CFG_PARITY_EN.
module x_lut_cfg_loader #(
   parameter int CHAIN_BITS = 16,
   parameter int W          = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_cfg_start,
   input  logic         i_abort,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   output logic         o_ready,
   output logic         o_chain_data,
   output logic         o_chain_en,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_parity
);

   localparam int CW = $clog2(CHAIN_BITS + 1);
   localparam int RW = $clog2(W + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_BITS - 1);
   localparam logic [RW-1:0] REM_FULL = RW'(W);
   localparam logic [RW-1:0] REM_ONE  = RW'(1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  hold_q, hold_d;
   logic [RW-1:0] rem_q, rem_d;
   logic          data_q, data_d;
   logic          emit;
   logic          accept;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         rem_q   <= '0;
         data_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      rem_d   = rem_q;
      emit    = (state_q == S_LOAD) && (rem_q != '0);
      // Refill while empty, or on the last bit of the held word if more bits are still owed.
      o_ready = (state_q == S_LOAD) &&
                ((rem_q == '0) || ((rem_q == REM_ONE) && (cnt_q < CNT_LAST)));
      accept       = o_ready && i_valid && !i_abort;
      o_chain_en   = emit;
      o_chain_data = emit ? hold_q[W-1] : data_q;
      data_d       = o_chain_data;
      o_busy       = (state_q == S_LOAD);
      o_done       = (state_q == S_DONE);
      case (state_q)
         S_IDLE: begin
            if (i_cfg_start) begin
               state_d = S_LOAD;
               cnt_d   = '0;
               rem_d   = '0;
            end
         end
         S_LOAD: begin
            if (i_abort) begin
               state_d = S_IDLE;
               rem_d   = '0;
            end else begin
               if (emit) begin
                  hold_d = hold_q << 1;
                  rem_d  = rem_q - REM_ONE;
                  cnt_d  = cnt_q + CW'(1);
                  // Low bits of a partial final word are dropped by emptying the holder here.
                  if (cnt_q == CNT_LAST) begin
                     state_d = S_DONE;
                     rem_d   = '0;
                  end
               end
               if (accept) begin
                  hold_d = i_data;
                  rem_d  = REM_FULL;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

`ifdef X_LUT_CFG_PARITY_EN
   logic parity_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         parity_q <= 1'b0;
      end else if ((state_q == S_IDLE) && i_cfg_start) begin
         parity_q <= 1'b0;
      end else if (emit) begin
         parity_q <= parity_q ^ hold_q[W-1];
      end
   end

   assign o_parity = parity_q;
`else
   assign o_parity = 1'b0;
`endif

endmodule
